// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - host-side operand feeder and result collector for a 4x4 int8 systolic array
//
// Purpose: holds matrices A and B written by the host, pulses the array reset for one
// cycle, streams skewed rowA/rowB words with enable/clk_count, latches rowC0..3 on the
// array done pulse and hands the four result rows back on a valid/ready stream.
// Optional feature macro: SYSTOLIC_FEEDER_TIMEOUT_EN (abort WAIT_DONE after TIMEOUT
// cycles and raise o_err); when undefined WAIT_DONE waits forever and o_err is 0.
//
// Ports:
//   systolic_clk, rst_n          clock shared with the array, async active-low reset
//   i_wr_en/i_wr_sel/i_wr_idx    host row write strobe, 0=A 1=B, row index k
//   i_wr_data                    row k, [31:24] = element [k][0]
//   i_start / o_busy             begin a multiply / run in progress
//   o_array_rst_n                array reset, low during reset and the CLEAR cycle
//   o_enable, o_clk_count        array enable and step counter (4'hF when idle)
//   o_row_a, o_row_b             skewed operand words
//   i_array_done, i_array_row_c0..3  array done pulse and result rows
//   o_c_valid/i_c_ready/o_c_idx/o_c_data  result row stream
//   o_err                        sticky timeout flag, cleared by start
module systolic_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_SIZE  = 8,
  parameter int DIM_SIZE   = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                        systolic_clk,
  input  logic                        rst_n,
  input  logic                        i_wr_en,
  input  logic                        i_wr_sel,
  input  logic [$clog2(DIM_SIZE)-1:0] i_wr_idx,
  input  logic [DATA_WIDTH-1:0]       i_wr_data,
  input  logic                        i_start,
  output logic                        o_busy,
  output logic                        o_array_rst_n,
  output logic                        o_enable,
  output logic [3:0]                  o_clk_count,
  output logic [DATA_WIDTH-1:0]       o_row_a,
  output logic [DATA_WIDTH-1:0]       o_row_b,
  input  logic                        i_array_done,
  input  logic [DATA_WIDTH-1:0]       i_array_row_c0,
  input  logic [DATA_WIDTH-1:0]       i_array_row_c1,
  input  logic [DATA_WIDTH-1:0]       i_array_row_c2,
  input  logic [DATA_WIDTH-1:0]       i_array_row_c3,
  output logic                        o_c_valid,
  input  logic                        i_c_ready,
  output logic [$clog2(DIM_SIZE)-1:0] o_c_idx,
  output logic [DATA_WIDTH-1:0]       o_c_data,
  output logic                        o_err
);
  localparam int IDX_W    = $clog2(DIM_SIZE);
  localparam int FEED_LEN = 3 * DIM_SIZE - 1;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_t;
  logic [IDX_W-1:0]      r_cidx;
  logic [DATA_WIDTH-1:0] r_a [DIM_SIZE];
  logic [DATA_WIDTH-1:0] r_b [DIM_SIZE];
  logic [DATA_WIDTH-1:0] r_c [DIM_SIZE];
  logic                  w_timeout;
  logic                  w_err;
  logic                  w_clr;

`ifdef SYSTOLIC_FEEDER_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_err;

  assign w_timeout = (r_state == S_WAIT) && !i_array_done &&
                     (r_wcnt == WCNT_W'(TIMEOUT - 1));
  assign w_err     = r_err;

  always_ff @(posedge systolic_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wcnt <= (r_state == S_WAIT) ? r_wcnt + 1'b1 : '0;
      if (r_state == S_IDLE && i_start) r_err <= 1'b0;
      else if (w_timeout)               r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_err     = 1'b0;
`endif

  // State register
  always_ff @(posedge systolic_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLEAR;
      S_CLEAR: w_next = S_FEED;
      S_FEED:  if (r_t == 4'(FEED_LEN - 1)) w_next = S_WAIT;
      S_WAIT:  begin
        if (i_array_done)   w_next = S_DRAIN;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DRAIN: if (i_c_ready && r_cidx == IDX_W'(DIM_SIZE - 1)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Matrix storage; host writes only land while idle
  always_ff @(posedge systolic_clk) begin
    if (r_state == S_IDLE && i_wr_en) begin
      if (i_wr_sel) r_b[i_wr_idx] <= i_wr_data;
      else          r_a[i_wr_idx] <= i_wr_data;
    end
  end

  // Feed step counter, result buffer and drain index
  always_ff @(posedge systolic_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t    <= '0;
      r_cidx <= '0;
      for (int i = 0; i < DIM_SIZE; i++) r_c[i] <= '0;
    end else begin
      r_t <= (r_state == S_FEED) ? r_t + 4'd1 : 4'd0;
      if (r_state == S_WAIT && i_array_done) begin
        r_c[0] <= i_array_row_c0;
        r_c[1] <= i_array_row_c1;
        r_c[2] <= i_array_row_c2;
        r_c[3] <= i_array_row_c3;
      end
      if (r_state != S_DRAIN) r_cidx <= '0;
      else if (i_c_ready)     r_cidx <= r_cidx + 1'b1;
    end
  end

  // Outputs. Element k of row r enters at step t = r + k, so the operands for
  // PE(r,c) meet after c + r hops of propagation inside the array.
  always_comb begin
    w_clr         = (r_state == S_CLEAR);
    o_busy        = (r_state != S_IDLE);
    o_array_rst_n = rst_n & ~w_clr;
    o_enable      = (r_state == S_FEED);
    o_clk_count   = (r_state == S_FEED) ? r_t : 4'hF;
    o_row_a       = '0;
    o_row_b       = '0;
    if (r_state == S_FEED) begin
      for (int r = 0; r < DIM_SIZE; r++) begin
        for (int k = 0; k < DIM_SIZE; k++) begin
          if (int'(r_t) == r + k) begin
            o_row_a[DATA_WIDTH-1-r*DATA_SIZE -: DATA_SIZE] = r_a[r][DATA_WIDTH-1-k*DATA_SIZE -: DATA_SIZE];
            o_row_b[DATA_WIDTH-1-r*DATA_SIZE -: DATA_SIZE] = r_b[k][DATA_WIDTH-1-r*DATA_SIZE -: DATA_SIZE];
          end
        end
      end
    end
    o_c_valid = (r_state == S_DRAIN);
    o_c_idx   = r_cidx;
    o_c_data  = (r_state == S_DRAIN) ? r_c[r_cidx] : '0;
    o_err     = w_err;
  end
endmodule
